// File: rtl/time_skew_pkg.sv
// Shared widths and record types for the two-stage skew generator.
// A word carries the stage-1 MSBs above the stage-2 LSBs, matching din_i[5:3]/[2:0].
package time_skew_pkg;

  localparam int MSB_W  = 3;
  localparam int LSB_W  = 3;
  localparam int DATA_W = MSB_W + LSB_W;

  typedef struct packed {
    logic [MSB_W-1:0] msb;
    logic [LSB_W-1:0] lsb;
  } word_t;

  typedef struct packed {
    logic             valid;
    logic [LSB_W-1:0] lsb;
  } lsb_slot_t;

endpackage

// File: rtl/time_skew_fifo.sv
// First-word-fall-through FIFO with occupancy count; the head entry is visible on rdata while not empty.
// A word written at one edge is readable from the next edge only (no empty bypass).
module time_skew_fifo
  import time_skew_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = word_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  T                             wdata,
  input  logic                         pop,
  output T                             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  T                 mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LVL_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/time_skew_2stage.sv
// Skew generator: emits each word's MSBs on pop and its LSBs SKEW enabled edges later.
// en_i low freezes pop and shift; the output data holds while both valids drop for that cycle.
module time_skew_2stage
  import time_skew_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SKEW  = 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [DATA_W-1:0]           din_i,
  input  logic                        din_valid_i,
  output logic                        din_ready_o,
  input  logic                        en_i,
  output logic [MSB_W-1:0]            msb_o,
  output logic                        msb_valid_o,
  output logic [LSB_W-1:0]            lsb_o,
  output logic                        lsb_valid_o,
  output logic [$clog2(DEPTH+1)-1:0]  level_o
);

  word_t     head;
  logic      full;
  logic      empty;
  logic      push;
  logic      pop;
  lsb_slot_t slot_in;
  lsb_slot_t sr [SKEW];

  // Handshake: a word transfers at a rising edge where din_valid_i && din_ready_o;
  // ready depends only on fullness and reset, never on en_i or a same-cycle pop.
  assign din_ready_o = !full && !reset_i;
  assign push        = din_valid_i && din_ready_o;
  assign pop         = en_i && !empty;

  time_skew_fifo #(
    .DEPTH (DEPTH),
    .T     (word_t)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (reset_i),
    .push  (push),
    .wdata (word_t'(din_i)),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level_o)
  );

  always_comb begin
    slot_in = '0;
    if (pop) begin
      slot_in.valid = 1'b1;
      slot_in.lsb   = head.lsb;
    end
  end

  // sr[0] takes the slot at the pop edge; the output register adds the final stage,
  // giving SKEW enabled edges between msb_o and lsb_o of the same word.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      msb_o       <= '0;
      msb_valid_o <= 1'b0;
      lsb_o       <= '0;
      lsb_valid_o <= 1'b0;
      for (int i = 0; i < SKEW; i++) sr[i] <= '0;
    end else if (en_i) begin
      msb_o       <= pop ? head.msb : '0;
      msb_valid_o <= pop;
      sr[0]       <= slot_in;
      for (int i = 1; i < SKEW; i++) sr[i] <= sr[i-1];
      lsb_o       <= sr[SKEW-1].lsb;
      lsb_valid_o <= sr[SKEW-1].valid;
    end else begin
      msb_valid_o <= 1'b0;
      lsb_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_time_skew_2stage.sv
// Bench for time_skew_2stage: directed timing checks plus an in-order scoreboard on msb/lsb outputs.
module tb_time_skew_2stage;
  import time_skew_pkg::*;

  localparam int DEPTH = 4;
  localparam int SKEW  = 1;
  localparam int LVL_W = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             reset_i;
  logic [5:0]       din_i;
  logic             din_valid_i;
  logic             din_ready_o;
  logic             en_i;
  logic [2:0]       msb_o;
  logic             msb_valid_o;
  logic [2:0]       lsb_o;
  logic             lsb_valid_o;
  logic [LVL_W-1:0] level_o;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [2:0] exp_msb_q[$];
  logic [2:0] exp_lsb_q[$];
  int         run_len  = 0;
  int         max_run  = 0;
  int         out_seen = 0;
  int         snap;
  logic [5:0] full_words [5];

  time_skew_2stage #(.DEPTH(DEPTH), .SKEW(SKEW)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .din_i       (din_i),
    .din_valid_i (din_valid_i),
    .din_ready_o (din_ready_o),
    .en_i        (en_i),
    .msb_o       (msb_o),
    .msb_valid_o (msb_valid_o),
    .lsb_o       (lsb_o),
    .lsb_valid_o (lsb_valid_o),
    .level_o     (level_o)
  );

  // clock/reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && (exp_msb_q.size() != 0 || exp_lsb_q.size() != 0); i++) tick();
    check(tag, 8'(exp_msb_q.size() + exp_lsb_q.size()), 8'h00);
  endtask

  // scoreboard: outputs compared and acceptances recorded on the falling edge
  always @(negedge clk) begin
    if (!reset_i) begin
      if (msb_valid_o) begin
        out_seen++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (exp_msb_q.size() == 0) check("msb_extra", 8'(msb_o), 8'hFF);
        else check("msb_order", 8'(msb_o), 8'(exp_msb_q.pop_front()));
      end else begin
        run_len = 0;
      end
      if (lsb_valid_o) begin
        out_seen++;
        if (exp_lsb_q.size() == 0) check("lsb_extra", 8'(lsb_o), 8'hFF);
        else check("lsb_order", 8'(lsb_o), 8'(exp_lsb_q.pop_front()));
      end
      if (din_valid_i && din_ready_o) begin
        exp_msb_q.push_back(din_i[5:3]);
        exp_lsb_q.push_back(din_i[2:0]);
      end
    end
  end

  initial begin
    full_words[0] = 6'h15; full_words[1] = 6'h2A; full_words[2] = 6'h33;
    full_words[3] = 6'h0C; full_words[4] = 6'h3F;

    // reset held with valid input
    reset_i = 1'b1; din_valid_i = 1'b1; din_i = 6'h3F; en_i = 1'b1;
    repeat (3) tick();
    check("rst_msb", 8'(msb_o), 8'h00);
    check("rst_msb_valid", 8'(msb_valid_o), 8'h00);
    check("rst_lsb", 8'(lsb_o), 8'h00);
    check("rst_lsb_valid", 8'(lsb_valid_o), 8'h00);
    check("rst_level", 8'(level_o), 8'h00);
    check("rst_ready", 8'(din_ready_o), 8'h00);
    din_valid_i = 1'b0;
    reset_i = 1'b0;
    #1;
    check("rel_ready", 8'(din_ready_o), 8'h01);
    check("rel_level", 8'(level_o), 8'h00);
    tick();

    // single word latency
    din_i = 6'b101_011; din_valid_i = 1'b1;
    tick();
    din_valid_i = 1'b0;
    check("sw_k_msb_valid", 8'(msb_valid_o), 8'h00);
    check("sw_k_level", 8'(level_o), 8'h01);
    tick();
    check("sw_k1_msb_valid", 8'(msb_valid_o), 8'h01);
    check("sw_k1_msb", 8'(msb_o), 8'h05);
    check("sw_k1_lsb_valid", 8'(lsb_valid_o), 8'h00);
    tick();
    check("sw_k2_msb_valid", 8'(msb_valid_o), 8'h00);
    check("sw_k2_msb", 8'(msb_o), 8'h00);
    check("sw_k2_lsb_valid", 8'(lsb_valid_o), 8'h01);
    check("sw_k2_lsb", 8'(lsb_o), 8'h03);
    tick();
    check("sw_k3_lsb_valid", 8'(lsb_valid_o), 8'h00);

    // back-to-back stream
    max_run = 0;
    for (int i = 0; i < 64; i++) begin
      din_i = 6'(i); din_valid_i = 1'b1;
      tick();
    end
    din_valid_i = 1'b0;
    drain("stream_drain");
    check("stream_run", 8'(max_run), 8'd64);
    check("stream_level", 8'(level_o), 8'h00);

    // fill while frozen, then drain
    en_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din_i = full_words[i]; din_valid_i = 1'b1;
      tick();
    end
    din_i = full_words[4];
    check("full_ready", 8'(din_ready_o), 8'h00);
    check("full_level", 8'(level_o), 8'h04);
    tick();
    check("full_hold_level", 8'(level_o), 8'h04);
    en_i = 1'b1;
    tick();
    check("pop_level", 8'(level_o), 8'h03);
    check("pop_ready", 8'(din_ready_o), 8'h01);
    tick();
    check("pushpop_level", 8'(level_o), 8'h03);
    din_valid_i = 1'b0;
    drain("full_drain");

    // freeze mid-flight
    din_i = 6'h2E; din_valid_i = 1'b1;
    tick();
    din_valid_i = 1'b0;
    tick();
    check("frz_msb", 8'(msb_o), 8'h05);
    en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frz_lsb_valid", 8'(lsb_valid_o), 8'h00);
      check("frz_msb_valid", 8'(msb_valid_o), 8'h00);
      check("frz_msb_hold", 8'(msb_o), 8'h05);
    end
    en_i = 1'b1;
    tick();
    check("frz_resume_lsb_valid", 8'(lsb_valid_o), 8'h01);
    check("frz_resume_lsb", 8'(lsb_o), 8'h06);
    drain("frz_drain");

    // asynchronous reset with queued words and a pending LSB
    din_i = 6'h2D; din_valid_i = 1'b1;
    tick();
    din_valid_i = 1'b0;
    tick();
    en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din_i = 6'(6'h11 + 6'(i * 9)); din_valid_i = 1'b1;
      tick();
    end
    din_valid_i = 1'b0;
    check("mid_level", 8'(level_o), 8'h03);
    check("mid_msb_hold", 8'(msb_o), 8'h05);
    #2 reset_i = 1'b1;
    #1;
    check("mid_rst_msb", 8'(msb_o), 8'h00);
    check("mid_rst_lsb_valid", 8'(lsb_valid_o), 8'h00);
    check("mid_rst_level", 8'(level_o), 8'h00);
    check("mid_rst_ready", 8'(din_ready_o), 8'h00);
    reset_i = 1'b0;
    exp_msb_q.delete();
    exp_lsb_q.delete();
    en_i = 1'b1;
    snap = out_seen;
    repeat (8) tick();
    check("mid_post_outputs", 8'(out_seen - snap), 8'h00);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      din_i       = 6'($urandom_range(0, 63));
      din_valid_i = 1'($urandom_range(0, 1));
      en_i        = ($urandom_range(0, 3) != 0);
      tick();
    end
    din_valid_i = 1'b0;
    en_i = 1'b1;
    drain("rand_drain");
    check("rand_level", 8'(level_o), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
